pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline-stage register for the RISC-V core. It replaces the fixed per-stage registers, which use a global stall/flush vector, with a valid/ready handshake and a two-entry skid buffer. This lets stages stall locally without a combinational ready path running through the pipeline. Every inter-stage boundary instantiates it, with the payload packed as a single vector.

---
 rtl/pipe_stage_skid.sv | 86 ++++++++
 tb/tb_pipe_stage_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and an optional skid entry,
// so each stage can stall locally without a combinational ready chain.
module pipe_stage_skid #(
   parameter int                    DATA_WIDTH   = 64,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {DATA_WIDTH{1'b0}},
   parameter bit                    SKID         = 1'b1,
   parameter int                    CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  stall_cycles
);

   logic                  main_valid;
   logic [DATA_WIDTH-1:0] main_data;
   logic                  skid_valid;
   logic                  in_xfer;
   logic                  out_xfer;

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = main_valid && out_ready;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   if (SKID) begin : g_skid
      logic                  skid_q;
      logic [DATA_WIDTH-1:0] skid_data;

      // in_ready comes straight from the skid flop, never from out_ready
      assign skid_valid = skid_q;
      assign in_ready   = !skid_q;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            main_valid <= 1'b0;
            skid_q     <= 1'b0;
            main_data  <= BUBBLE_VALUE;
         end else if (skid_q && out_xfer) begin
            main_data <= skid_data;
            skid_q    <= 1'b0;
         end else if (in_xfer && (!main_valid || out_xfer)) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
         end else if (in_xfer) begin
            skid_data <= in_data;
            skid_q    <= 1'b1;
         end else if (out_xfer) begin
            main_valid <= 1'b0;
         end
      end
   end else begin : g_single
      assign skid_valid = 1'b0;
      assign in_ready   = !main_valid || out_ready;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
         end else if (in_xfer) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
         end else if (out_xfer) begin
            main_valid <= 1'b0;
         end
      end
   end

   // Backpressure counter survives flush so stalls can be profiled across kills
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (main_valid && !out_ready && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid mode, single-entry mode and a
// narrow-counter instance sharing the skid-mode stimulus.
module tb_pipe_stage_skid;

   localparam logic [15:0] BUBBLE = 16'hDEAD;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid;
   logic [15:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cycles;

   logic        c_in_ready, c_out_valid;
   logic [15:0] c_out_data;
   logic [1:0]  c_occupancy;
   logic [1:0]  c_stall;

   logic        z_reset, z_flush, z_in_valid, z_out_ready;
   logic [15:0] z_in_data;
   logic        z_in_ready, z_out_valid;
   logic [15:0] z_out_data;
   logic [1:0]  z_occupancy;
   logic [15:0] z_stall;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_WIDTH(16), .BUBBLE_VALUE(BUBBLE), .SKID(1'b1), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cycles(stall_cycles));

   pipe_stage_skid #(.DATA_WIDTH(16), .BUBBLE_VALUE(BUBBLE), .SKID(1'b1), .CNT_WIDTH(2)) dutc (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .occupancy(c_occupancy), .stall_cycles(c_stall));

   pipe_stage_skid #(.DATA_WIDTH(16), .BUBBLE_VALUE(BUBBLE), .SKID(1'b0), .CNT_WIDTH(16)) dutz (
      .clk(clk), .reset(z_reset), .flush(z_flush),
      .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
      .occupancy(z_occupancy), .stall_cycles(z_stall));

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0);
      z_reset = 1'b1; z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = 16'h0; z_out_ready = 1'b0;
      tick(); tick();

      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, BUBBLE);
      checkOutput("rst_occupancy", occupancy, 0);
      checkOutput("rst_stall", stall_cycles, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      // Streaming at full throughput
      applyStimulus(1'b1, 16'h1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         checkOutput($sformatf("stream_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("stream_data_%0d", i), out_data, i);
         checkOutput($sformatf("stream_occ_%0d", i), occupancy, 1);
         checkOutput($sformatf("stream_rdy_%0d", i), in_ready, 1);
         if (i < 8) applyStimulus(1'b1, 16'(i + 1), 1'b1);
         else       applyStimulus(1'b0, 16'h0, 1'b1);
      end
      tick();
      checkOutput("drain_valid", out_valid, 0);
      checkOutput("drain_keeps_data", out_data, 16'h8);
      checkOutput("stream_stall", stall_cycles, 0);

      // Backpressure fills the skid entry
      applyStimulus(1'b1, 16'hA, 1'b1);
      tick();
      checkOutput("bp_a", out_data, 16'hA);
      applyStimulus(1'b1, 16'hB, 1'b0);
      tick();
      checkOutput("bp_occ2", occupancy, 2);
      checkOutput("bp_rdy0", in_ready, 0);
      checkOutput("bp_hold_a", out_data, 16'hA);
      applyStimulus(1'b1, 16'hC, 1'b0);
      tick();
      checkOutput("bp_occ2_hold", occupancy, 2);
      checkOutput("bp_hold_a2", out_data, 16'hA);
      applyStimulus(1'b1, 16'hC, 1'b1);
      tick();
      checkOutput("bp_b", out_data, 16'hB);
      checkOutput("bp_b_valid", out_valid, 1);
      checkOutput("bp_occ1", occupancy, 1);
      checkOutput("bp_rdy1", in_ready, 1);
      tick();
      checkOutput("bp_c", out_data, 16'hC);
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick();
      checkOutput("bp_empty", out_valid, 0);
      checkOutput("bp_stall", stall_cycles, 2);
      checkOutput("bp_stall_narrow", c_stall, 2);

      // Flush at occupancy 2 with a payload on the input
      applyStimulus(1'b1, 16'h11, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h12, 1'b0);
      tick();
      checkOutput("fl_occ2", occupancy, 2);
      flush = 1'b1;
      applyStimulus(1'b1, 16'hD, 1'b0);
      tick();
      checkOutput("fl_valid", out_valid, 0);
      checkOutput("fl_occ", occupancy, 0);
      checkOutput("fl_data", out_data, BUBBLE);
      checkOutput("fl_rdy", in_ready, 1);
      flush = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick(); tick();
      checkOutput("fl_no_d", out_valid, 0);
      checkOutput("fl_data_kept", out_data, BUBBLE);
      checkOutput("fl_stall", stall_cycles, 4);
      checkOutput("fl_stall_sat", c_stall, 3);

      // Stall counting, saturation and survival across flush
      reset = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0);
      tick();
      checkOutput("cnt_rst", stall_cycles, 0);
      checkOutput("cnt_rst_narrow", c_stall, 0);
      reset = 1'b0;
      applyStimulus(1'b1, 16'h21, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         checkOutput($sformatf("cnt_%0d", i), stall_cycles, i);
         checkOutput($sformatf("cnt_narrow_%0d", i), c_stall, (i > 3) ? 3 : i);
      end
      flush = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick();
      checkOutput("cnt_flush_valid", out_valid, 0);
      checkOutput("cnt_after_flush", stall_cycles, 5);
      flush = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0);
      tick();
      checkOutput("cnt_idle", stall_cycles, 5);

      // Reset in the middle of backpressure, then resume
      applyStimulus(1'b1, 16'h31, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h32, 1'b0);
      tick();
      checkOutput("rbp_occ2", occupancy, 2);
      reset = 1'b1;
      applyStimulus(1'b1, 16'h33, 1'b0);
      tick();
      checkOutput("rbp_valid", out_valid, 0);
      checkOutput("rbp_occ", occupancy, 0);
      checkOutput("rbp_data", out_data, BUBBLE);
      checkOutput("rbp_stall", stall_cycles, 0);
      checkOutput("rbp_rdy", in_ready, 1);
      reset = 1'b0;
      applyStimulus(1'b1, 16'h34, 1'b1);
      tick();
      checkOutput("rbp_resume_34", out_data, 16'h34);
      checkOutput("rbp_resume_valid", out_valid, 1);
      applyStimulus(1'b1, 16'h35, 1'b1);
      tick();
      checkOutput("rbp_resume_35", out_data, 16'h35);
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick();
      checkOutput("rbp_drain", out_valid, 0);

      // Single-entry mode
      checkOutput("z_rst_valid", z_out_valid, 0);
      checkOutput("z_rst_occ", z_occupancy, 0);
      checkOutput("z_rst_data", z_out_data, BUBBLE);
      checkOutput("z_rst_rdy", z_in_ready, 1);
      z_reset = 1'b0;
      z_in_valid = 1'b1; z_in_data = 16'h51; z_out_ready = 1'b1;
      tick();
      checkOutput("z_s51", z_out_data, 16'h51);
      z_in_data = 16'h52;
      tick();
      checkOutput("z_s52", z_out_data, 16'h52);
      checkOutput("z_s52_occ", z_occupancy, 1);
      z_in_valid = 1'b0;
      tick();
      checkOutput("z_drain", z_out_valid, 0);
      z_in_valid = 1'b1; z_in_data = 16'h41; z_out_ready = 1'b0;
      tick();
      checkOutput("z_41", z_out_data, 16'h41);
      z_in_data = 16'h42;
      #1;
      checkOutput("z_rdy_comb0", z_in_ready, 0);
      tick();
      checkOutput("z_hold_41", z_out_data, 16'h41);
      checkOutput("z_hold_occ", z_occupancy, 1);
      z_in_data = 16'hE; z_out_ready = 1'b1;
      #1;
      checkOutput("z_rdy_comb1", z_in_ready, 1);
      tick();
      checkOutput("z_e", z_out_data, 16'hE);
      checkOutput("z_e_valid", z_out_valid, 1);
      z_in_valid = 1'b0;
      tick();
      checkOutput("z_e_drain", z_out_valid, 0);
      checkOutput("z_e_kept", z_out_data, 16'hE);
      checkOutput("z_stall", z_stall, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
